// File: rtl/key_schedule_seq_pkg.sv
// Shared AES cipher definitions: byte/word/state types, S-box and round constants.
package key_schedule_seq_pkg;

   typedef logic [7:0]   byte_t;
   typedef byte_t [0:3]  word_t;
   typedef word_t [0:3]  state_t;

   localparam logic [3:0] Nr = 4'd10;

   // Row r holds S-box entries 16*r .. 16*r+15, entry 0 in the MSB byte.
   localparam logic [0:255][7:0] Sbox = {
      128'h637c777bf26b6fc53001672bfed7ab76,
      128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115,
      128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84,
      128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8,
      128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973,
      128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479,
      128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
      128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df,
      128'h8ca1890dbfe6426841992d0fb054bb16
   };

   // Indexed directly by the 4-bit round number; only entries 1..10 are meaningful.
   localparam logic [0:15][7:0] Rcon = {
      8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
      8'h80, 8'h1b, 8'h36, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00
   };

endpackage

// File: rtl/key_schedule_seq_sub_word.sv
// SubWord: four parallel S-box lookups on one 32-bit word.
module key_schedule_seq_sub_word
   import key_schedule_seq_pkg::*;
(
   input  logic [0:3][7:0] i_word,
   output logic [0:3][7:0] o_word
);

   always_comb begin
      o_word = '0;
      for (int i = 0; i < 4; i++) begin
         o_word[i] = Sbox[i_word[i]];
      end
   end

endmodule

// File: rtl/key_schedule_seq.sv
// Iterative AES-128 key expansion: emits round keys 0..10, one per valid/ready handshake.
module key_schedule_seq
   import key_schedule_seq_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   output logic                 start_ready,
   input  logic [0:3][0:3][7:0] cipher_key,
   output logic [0:3][0:3][7:0] rk,
   output logic [3:0]           rk_round,
   output logic                 rk_valid,
   input  logic                 rk_ready,
   output logic                 rk_last
);

   localparam logic ST_IDLE = 1'b0;
   localparam logic ST_RUN  = 1'b1;

   logic       r_state;
   state_t     r_rk;
   logic [3:0] r_round;

   word_t      w_rot;
   word_t      w_sub;
   word_t      w_temp;
   state_t     w_next;
   logic [3:0] w_next_round;

   assign w_rot        = {r_rk[3][1], r_rk[3][2], r_rk[3][3], r_rk[3][0]};
   assign w_next_round = r_round + 4'd1;

   key_schedule_seq_sub_word u_sub_word (
      .i_word (w_rot),
      .o_word (w_sub)
   );

   always_comb begin
      w_temp    = w_sub ^ {Rcon[w_next_round], 24'h00_0000};
      w_next[0] = r_rk[0] ^ w_temp;
      w_next[1] = r_rk[1] ^ w_next[0];
      w_next[2] = r_rk[2] ^ w_next[1];
      w_next[3] = r_rk[3] ^ w_next[2];
   end

   // start is only honoured in IDLE; in RUN it is dropped, not queued.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_IDLE;
         r_rk    <= '0;
         r_round <= '0;
      end else if (r_state == ST_IDLE) begin
         if (start) begin
            r_rk    <= cipher_key;
            r_round <= '0;
            r_state <= ST_RUN;
         end
      end else if (rk_ready) begin
         if (r_round == Nr) begin
            r_state <= ST_IDLE;
         end else begin
            r_rk    <= w_next;
            r_round <= w_next_round;
         end
      end
   end

   assign start_ready = (r_state == ST_IDLE);
   assign rk_valid    = (r_state == ST_RUN);
   assign rk_last     = rk_valid && (r_round == Nr);
   assign rk          = r_rk;
   assign rk_round    = r_round;

endmodule

// File: tb/tb_key_schedule_seq.sv
// Scoreboard bench for key_schedule_seq; S-box model derived from GF(2^8) inverse + affine map.
module tb_key_schedule_seq;

   typedef logic [0:3][0:3][7:0] key_t;
   typedef struct packed {
      logic [3:0] round;
      key_t       key;
   } exp_t;

   localparam key_t FipsKey  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam key_t OtherKey = 128'h000102030405060708090a0b0c0d0e0f;
   localparam key_t ThirdKey = 128'h0f1571c947d9e8590cb7add6af7f6798;
   localparam key_t FipsR1   = 128'ha0fafe1788542cb123a339392a6c7605;
   localparam key_t FipsR2   = 128'hf2c295f27a96b9435935807a7359f67f;
   localparam key_t FipsR10  = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
   localparam key_t ZeroR1   = 128'h62636363626363636263636362636363;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       start = 1'b0;
   logic       rk_ready = 1'b0;
   key_t       cipher_key = '0;
   key_t       rk;
   logic [3:0] rk_round;
   logic       rk_valid;
   logic       rk_last;
   logic       start_ready;

   int         n_checks = 0;
   int         n_errors = 0;
   exp_t       q[$];
   logic [7:0] m_sbox [256];

   key_schedule_seq dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .start_ready (start_ready),
      .cipher_key  (cipher_key),
      .rk          (rk),
      .rk_round    (rk_round),
      .rk_valid    (rk_valid),
      .rk_ready    (rk_ready),
      .rk_last     (rk_last)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] xtime(input logic [7:0] x);
      return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p = 8'h00;
      logic [7:0] x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = xtime(x);
      end
      return p;
   endfunction

   function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
      logic [15:0] t = {b, b};
      t = t << n;
      return t[15:8];
   endfunction

   function automatic void build_sbox();
      for (int x = 0; x < 256; x++) begin
         logic [7:0] inv = 8'h01;
         for (int k = 0; k < 254; k++) inv = gf_mul(inv, 8'(x));
         m_sbox[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
      end
   endfunction

   function automatic key_t next_key(input key_t w, input logic [7:0] rc);
      logic [0:3][7:0] t;
      key_t n;
      t = {m_sbox[w[3][1]] ^ rc, m_sbox[w[3][2]], m_sbox[w[3][3]], m_sbox[w[3][0]]};
      n[0] = w[0] ^ t;
      n[1] = w[1] ^ n[0];
      n[2] = w[2] ^ n[1];
      n[3] = w[3] ^ n[2];
      return n;
   endfunction

   function automatic void push_expected(input key_t k);
      key_t w = k;
      logic [7:0] rc = 8'h01;
      exp_t e;
      e.round = 4'd0;
      e.key   = w;
      q.push_back(e);
      for (int r = 1; r <= 10; r++) begin
         w = next_key(w, rc);
         rc = xtime(rc);
         e.round = 4'(r);
         e.key   = w;
         q.push_back(e);
      end
   endfunction

   task automatic test_reset();
      n_checks++;
      if (start_ready !== 1'b1) begin
         n_errors++; $display("FAIL reset_start_ready got=%b want=1", start_ready);
      end
      n_checks++;
      if (rk_valid !== 1'b0) begin
         n_errors++; $display("FAIL reset_rk_valid got=%b want=0", rk_valid);
      end
      n_checks++;
      if (rk_round !== 4'd0) begin
         n_errors++; $display("FAIL reset_rk_round got=%0d want=0", rk_round);
      end
      n_checks++;
      if (rk_last !== 1'b0) begin
         n_errors++; $display("FAIL reset_rk_last got=%b want=0", rk_last);
      end
      n_checks++;
      if (rk !== '0) begin
         n_errors++; $display("FAIL reset_rk got=%h want=0", rk);
      end
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
      n_checks++;
      if (rk_valid !== 1'b0 || start_ready !== 1'b1) begin
         n_errors++;
         $display("FAIL reset_release got valid=%b ready=%b want 0/1", rk_valid, start_ready);
      end
   endtask

   task automatic test_fips();
      exp_t e;
      q.delete();
      push_expected(FipsKey);
      rk_ready = 1'b1;
      cipher_key = FipsKey;
      start = 1'b1;
      n_checks++;
      if (start_ready !== 1'b1) begin
         n_errors++; $display("FAIL fips_start_ready got=%b want=1", start_ready);
      end
      @(posedge clk); #1;
      start = 1'b0;
      for (int i = 0; i <= 10; i++) begin
         e = q.pop_front();
         n_checks++;
         if (rk_valid !== 1'b1 || rk_round !== e.round || rk !== e.key) begin
            n_errors++;
            $display("FAIL fips_round%0d got v=%b r=%0d k=%h want v=1 r=%0d k=%h",
                     i, rk_valid, rk_round, rk, e.round, e.key);
         end
         n_checks++;
         if (rk_last !== (i == 10)) begin
            n_errors++; $display("FAIL fips_last%0d got=%b want=%b", i, rk_last, (i == 10));
         end
         if (i == 1 || i == 2 || i == 10) begin
            n_checks++;
            if (rk !== (i == 1 ? FipsR1 : (i == 2 ? FipsR2 : FipsR10))) begin
               n_errors++; $display("FAIL fips_vector%0d got=%h", i, rk);
            end
         end
         @(posedge clk); #1;
      end
      n_checks++;
      if (rk_valid !== 1'b0 || start_ready !== 1'b1 || rk !== FipsR10) begin
         n_errors++;
         $display("FAIL fips_idle got v=%b sr=%b k=%h want v=0 sr=1 k=%h",
                  rk_valid, start_ready, rk, FipsR10);
      end
   endtask

   task automatic test_stall();
      exp_t e;
      key_t prev_rk = '0;
      logic [3:0] prev_round = '0;
      bit stalled = 1'b0;
      int cyc = 0;
      q.delete();
      push_expected(FipsKey);
      cipher_key = FipsKey;
      start = 1'b1;
      rk_ready = 1'b0;
      @(posedge clk); #1;
      start = 1'b0;
      while (q.size() > 0 && cyc < 300) begin
         cyc++;
         if (stalled) begin
            n_checks++;
            if (rk !== prev_rk || rk_round !== prev_round) begin
               n_errors++;
               $display("FAIL stall_hold got r=%0d k=%h want r=%0d k=%h",
                        rk_round, rk, prev_round, prev_rk);
            end
         end
         e = q[0];
         n_checks++;
         if (rk_valid !== 1'b1 || rk_round !== e.round || rk !== e.key) begin
            n_errors++;
            $display("FAIL stall_key got v=%b r=%0d k=%h want v=1 r=%0d k=%h",
                     rk_valid, rk_round, rk, e.round, e.key);
            break;
         end
         rk_ready   = 1'($urandom_range(0, 1));
         prev_rk    = rk;
         prev_round = rk_round;
         stalled    = !rk_ready;
         if (rk_ready) void'(q.pop_front());
         @(posedge clk); #1;
      end
      n_checks++;
      if (q.size() != 0) begin
         n_errors++; $display("FAIL stall_complete got remaining=%0d want 0", q.size());
      end
      n_checks++;
      if (rk_valid !== 1'b0 || start_ready !== 1'b1) begin
         n_errors++; $display("FAIL stall_idle got v=%b sr=%b want 0/1", rk_valid, start_ready);
      end
      q.delete();
      rk_ready = 1'b1;
   endtask

   task automatic test_start_ignored();
      exp_t e;
      q.delete();
      push_expected(FipsKey);
      rk_ready = 1'b1;
      cipher_key = FipsKey;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      for (int i = 0; i <= 10; i++) begin
         e = q.pop_front();
         n_checks++;
         if (rk_valid !== 1'b1 || rk_round !== e.round || rk !== e.key) begin
            n_errors++;
            $display("FAIL ignore_round%0d got r=%0d k=%h want r=%0d k=%h",
                     i, rk_round, rk, e.round, e.key);
         end
         if (i == 4) begin
            n_checks++;
            if (start_ready !== 1'b0) begin
               n_errors++; $display("FAIL ignore_start_ready got=%b want=0", start_ready);
            end
            cipher_key = OtherKey;
            start = 1'b1;
         end else begin
            start = 1'b0;
         end
         @(posedge clk); #1;
      end
      n_checks++;
      if (rk_valid !== 1'b0) begin
         n_errors++; $display("FAIL ignore_idle got v=%b want 0", rk_valid);
      end
      @(posedge clk); #1;
      n_checks++;
      if (rk_valid !== 1'b0 || start_ready !== 1'b1) begin
         n_errors++; $display("FAIL ignore_not_queued got v=%b sr=%b want 0/1", rk_valid, start_ready);
      end
   endtask

   task automatic test_reset_mid();
      exp_t e;
      bit found = 1'b0;
      q.delete();
      rk_ready = 1'b1;
      cipher_key = FipsKey;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      for (int c = 0; c < 20; c++) begin
         if (rk_valid === 1'b1 && rk_round === 4'd6) begin
            found = 1'b1;
            break;
         end
         @(posedge clk); #1;
      end
      n_checks++;
      if (!found) begin
         n_errors++; $display("FAIL rstmid_reach6 got r=%0d want 6", rk_round);
      end
      #2 rst = 1'b1;
      #1;
      n_checks++;
      if (rk !== '0 || rk_round !== 4'd0 || rk_valid !== 1'b0 || rk_last !== 1'b0 ||
          start_ready !== 1'b1) begin
         n_errors++;
         $display("FAIL rstmid_outputs got k=%h r=%0d v=%b l=%b sr=%b want 0/0/0/0/1",
                  rk, rk_round, rk_valid, rk_last, start_ready);
      end
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
      n_checks++;
      if (rk_valid !== 1'b0) begin
         n_errors++; $display("FAIL rstmid_no_emit got v=%b want 0", rk_valid);
      end
      push_expected('0);
      cipher_key = '0;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      for (int i = 0; i <= 10; i++) begin
         e = q.pop_front();
         n_checks++;
         if (rk_valid !== 1'b1 || rk_round !== e.round || rk !== e.key) begin
            n_errors++;
            $display("FAIL zero_round%0d got r=%0d k=%h want r=%0d k=%h",
                     i, rk_round, rk, e.round, e.key);
         end
         if (i == 1) begin
            n_checks++;
            if (rk !== ZeroR1) begin
               n_errors++; $display("FAIL zero_vector1 got=%h want=%h", rk, ZeroR1);
            end
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_back_to_back();
      exp_t e;
      int gap = 0;
      q.delete();
      push_expected(OtherKey);
      rk_ready = 1'b1;
      cipher_key = OtherKey;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      gap = 1;
      for (int i = 0; i <= 10; i++) begin
         e = q.pop_front();
         n_checks++;
         if (rk_valid !== 1'b1 || rk_round !== e.round || rk !== e.key) begin
            n_errors++;
            $display("FAIL b2b_a_round%0d got r=%0d k=%h want r=%0d k=%h",
                     i, rk_round, rk, e.round, e.key);
         end
         @(posedge clk); #1;
         gap++;
      end
      n_checks++;
      if (start_ready !== 1'b1) begin
         n_errors++; $display("FAIL b2b_reenter got sr=%b want 1", start_ready);
      end
      push_expected(ThirdKey);
      cipher_key = ThirdKey;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      n_checks++;
      if (gap != 12) begin
         n_errors++; $display("FAIL b2b_spacing got=%0d want=12", gap);
      end
      for (int i = 0; i <= 10; i++) begin
         e = q.pop_front();
         n_checks++;
         if (rk_valid !== 1'b1 || rk_round !== e.round || rk !== e.key) begin
            n_errors++;
            $display("FAIL b2b_b_round%0d got v=%b r=%0d k=%h want v=1 r=%0d k=%h",
                     i, rk_valid, rk_round, rk, e.round, e.key);
         end
         @(posedge clk); #1;
      end
      n_checks++;
      if (rk_valid !== 1'b0 || start_ready !== 1'b1) begin
         n_errors++; $display("FAIL b2b_idle got v=%b sr=%b want 0/1", rk_valid, start_ready);
      end
   endtask

   initial begin
      rst = 1'b1;
      build_sbox();
      #1;
      test_reset();
      test_fips();
      test_stall();
      test_start_ignored();
      test_reset_mid();
      test_back_to_back();
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog got=timeout want=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
